// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding, line-level bit values and
// the default payload width.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT          = 1'b0;
  localparam logic STOP_BIT           = 1'b1;
  localparam int   DEFAULT_DATA_WIDTH = 8;

  // A one-bit payload still needs a one-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_parity.sv
// Transmit parity generator: PAR_TYP 0 gives even parity (XOR of the data),
// 1 gives odd parity (XNOR), matching the receive-side checker.
module uart_tx_parity #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity_bit
);

  assign parity_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, one serial bit per CLK cycle, optional parity bit.
// Define UART_TX_HOLD_REG_EN to add a one-entry holding register for back-to-back frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int              CNT_W    = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  parity_bit;

  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_par_en;
  logic                  hold_par_typ;

  uart_tx_parity #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data      (data_q),
    .par_typ   (par_typ_q),
    .parity_bit(parity_bit)
  );

`ifdef UART_TX_HOLD_REG_EN
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_par_en_q, hold_par_en_d;
  logic                  hold_par_typ_q, hold_par_typ_d;
  logic                  hold_pop;
  logic                  hold_capture;

  // The held word is consumed whenever the FSM can launch a frame from it.
  assign hold_pop     = hold_full_q && ((state_q == IDLE) || (state_q == STOP));
  assign hold_capture = busy_q && DATA_VALID && !hold_full_q;

  always_comb begin
    hold_full_d    = hold_full_q;
    hold_data_d    = hold_data_q;
    hold_par_en_d  = hold_par_en_q;
    hold_par_typ_d = hold_par_typ_q;
    if (hold_capture) begin
      hold_full_d    = 1'b1;
      hold_data_d    = P_DATA;
      hold_par_en_d  = PAR_EN;
      hold_par_typ_d = PAR_TYP;
    end else if (hold_pop) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_full_q    <= 1'b0;
      hold_data_q    <= '0;
      hold_par_en_q  <= 1'b0;
      hold_par_typ_q <= 1'b0;
    end else begin
      hold_full_q    <= hold_full_d;
      hold_data_q    <= hold_data_d;
      hold_par_en_q  <= hold_par_en_d;
      hold_par_typ_q <= hold_par_typ_d;
    end
  end

  assign hold_full    = hold_full_q;
  assign hold_data    = hold_data_q;
  assign hold_par_en  = hold_par_en_q;
  assign hold_par_typ = hold_par_typ_q;
`else
  assign hold_full    = 1'b0;
  assign hold_data    = '0;
  assign hold_par_en  = 1'b0;
  assign hold_par_typ = 1'b0;
`endif

  // Outputs are registered from the next state so the line never glitches.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    cnt_inc   = cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        tx_d   = STOP_BIT;
        busy_d = 1'b0;
        if (hold_full) begin
          state_d   = START;
          tx_d      = START_BIT;
          busy_d    = 1'b1;
          cnt_d     = '0;
          data_d    = hold_data;
          par_en_d  = hold_par_en;
          par_typ_d = hold_par_typ;
        end else if (DATA_VALID) begin
          state_d   = START;
          tx_d      = START_BIT;
          busy_d    = 1'b1;
          cnt_d     = '0;
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
        tx_d    = data_q[0];
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = parity_bit;
          end else begin
            state_d = STOP;
            tx_d    = STOP_BIT;
          end
        end else begin
          cnt_d = cnt_inc;
          tx_d  = data_q[cnt_inc];
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = STOP_BIT;
      end
      STOP: begin
        // A waiting word starts immediately, keeping Busy high with no idle gap.
        if (hold_full) begin
          state_d   = START;
          tx_d      = START_BIT;
          busy_d    = 1'b1;
          cnt_d     = '0;
          data_d    = hold_data;
          par_en_d  = hold_par_en;
          par_typ_d = hold_par_typ;
        end else begin
          state_d = IDLE;
          tx_d    = STOP_BIT;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = STOP_BIT;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= STOP_BIT;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle scoreboard of {Busy, TX_OUT}
// plus a loopback receiver that re-checks data and parity of every frame.
module tb_uart_tx;

  localparam int DW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          pen;
    logic          typ;
  } word_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          DATA_VALID = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          TX_OUT;
  logic          Busy;

  int total = 0;
  int bad   = 0;

  logic [1:0]    expQ[$];
  word_t         rxQ[$];
  bit            holdFull = 1'b0;
  word_t         holdWord;

  bit            rxActive = 1'b0;
  int            rxCnt = 0;
  word_t         rxWord;
  logic [DW-1:0] rxData;

  uart_tx #(
    .DATA_WIDTH(DW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Even parity makes the total count of ones even; odd makes it odd.
  function automatic logic parityOf(input word_t w);
    logic ones;
    ones = ^w.data;
    return w.typ ? ~ones : ones;
  endfunction

  task automatic pushFrame(input word_t w);
    expQ.push_back(2'b10);
    for (int i = 0; i < DW; i++) expQ.push_back({1'b1, w.data[i]});
    if (w.pen) expQ.push_back({1'b1, parityOf(w)});
    expQ.push_back(2'b11);
    rxQ.push_back(w);
  endtask

  // Receive-side checker fed with the sampled serial line.
  task automatic rxSample(input logic bitv);
    if (!rxActive) begin
      if (bitv == 1'b0) begin
        if (rxQ.size() == 0) begin
          checkOutput("rx_unexpected_start", 32'd1, 32'd0);
        end else begin
          rxWord   = rxQ.pop_front();
          rxActive = 1'b1;
          rxCnt    = 0;
          rxData   = '0;
        end
      end
    end else begin
      if (rxCnt < DW) begin
        rxData[rxCnt] = bitv;
      end else if (rxWord.pen && rxCnt == DW) begin
        checkOutput("rx_parity", {31'd0, ^{rxData, bitv}}, {31'd0, rxWord.typ});
      end else begin
        checkOutput("rx_stop", {31'd0, bitv}, 32'd1);
        checkOutput("rx_data", {24'd0, rxData}, {24'd0, rxWord.data});
        rxActive = 1'b0;
      end
      rxCnt++;
    end
  endtask

  // One cycle: check this cycle's outputs, advance the model, drive the next inputs.
  task automatic applyStimulus(input bit dv, input logic [DW-1:0] d, input bit pen, input bit typ);
    logic [1:0] e;
    bit         popped;
    bit         wasFull;
    word_t      w;
    @(negedge CLK);
    popped = 1'b0;
    if (expQ.size() > 0) begin
      e      = expQ.pop_front();
      popped = 1'b1;
    end else begin
      e = 2'b01;
    end
    checkOutput("busy", {31'd0, Busy}, {31'd0, e[1]});
    checkOutput("tx", {31'd0, TX_OUT}, {31'd0, e[0]});
    rxSample(TX_OUT);
    w       = '{data: d, pen: pen, typ: typ};
    wasFull = holdFull;
    if (!popped && holdFull) begin
      pushFrame(holdWord);
      holdFull = 1'b0;
    end else if (!popped && dv) begin
      pushFrame(w);
    end else if (popped && expQ.size() == 0 && wasFull) begin
      pushFrame(holdWord);
      holdFull = 1'b0;
    end
`ifdef UART_TX_HOLD_REG_EN
    if (popped && dv && !wasFull) begin
      holdFull = 1'b1;
      holdWord = w;
    end
`endif
    DATA_VALID = dv;
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = typ;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expQ.size() > 0 || holdFull) && n < 200) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      n++;
    end
    if (n >= 200) checkOutput("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic sendFrame(input logic [DW-1:0] d, input bit pen, input bit typ);
    applyStimulus(1'b1, d, pen, typ);
    drain();
  endtask

  initial begin
    $display("[TB] starting uart_tx bench");
    repeat (2) @(negedge CLK);
    checkOutput("reset_tx", {31'd0, TX_OUT}, 32'd1);
    checkOutput("reset_busy", {31'd0, Busy}, 32'd0);
    RST = 1'b1;
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    sendFrame(8'hA5, 1'b1, 1'b0);
    sendFrame(8'hA5, 1'b1, 1'b1);

    // No-parity frame with inputs wiggling mid-frame.
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(i[0], 8'hFF ^ 8'(i), 1'b1, 1'b1);
    drain();

    // DATA_VALID raised during the STOP cycle.
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    while (expQ.size() > 1) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    drain();
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a 0xFF frame.
    applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    checkOutput("abort_tx", {31'd0, TX_OUT}, 32'd1);
    checkOutput("abort_busy", {31'd0, Busy}, 32'd0);
    expQ.delete();
    rxQ.delete();
    rxActive = 1'b0;
    holdFull = 1'b0;
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    RST = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    sendFrame(8'h3C, 1'b1, 1'b1);

`ifdef UART_TX_HOLD_REG_EN
    applyStimulus(1'b1, 8'h12, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h34, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h56, 1'b1, 1'b0);
    drain();
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 256; i++) begin
      sendFrame(8'($urandom_range(0, 255)), 1'b1, i[0]);
    end
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("rx_leftover", rxQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
